// File: rtl/fir_packet_sequencer_if.sv
// Packet and core handshake bundle for fir_packet_sequencer.
// The slave side is the sequencer. The master side is the SPI slave and FIR core environment.
interface fir_packet_sequencer_if #(
    parameter int SAMPLES_NUM = 8,
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 32
);
    logic                             rxValidIn;
    logic [SAMPLES_NUM*IN_WIDTH-1:0]  rxDataIn;
    logic                             coreStartOut;
    logic [SAMPLES_NUM*IN_WIDTH-1:0]  coreDataOut;
    logic                             coreDoneIn;
    logic [SAMPLES_NUM*ACC_WIDTH-1:0] coreResultIn;
    logic [SAMPLES_NUM*OUT_WIDTH-1:0] txDataOut;
    logic                             busyOut;
    logic                             overrunOut;
    logic                             overrunClearIn;
    logic [15:0]                      frameCountOut;
    logic [7:0]                       dropCountOut;

    modport slave (
        input  rxValidIn, rxDataIn, coreDoneIn, coreResultIn, overrunClearIn,
        output coreStartOut, coreDataOut, txDataOut, busyOut, overrunOut,
               frameCountOut, dropCountOut
    );

    modport master (
        output rxValidIn, rxDataIn, coreDoneIn, coreResultIn, overrunClearIn,
        input  coreStartOut, coreDataOut, txDataOut, busyOut, overrunOut,
               frameCountOut, dropCountOut
    );
endinterface

// File: rtl/fir_packet_sequencer.sv
// Sequencer between the SPI slave and the FIR core. It unpacks packets and launches the core.
// It also scales results, double-buffers them for transmit, and counts accepted and dropped packets.
module fir_packet_sequencer #(
    parameter int SAMPLES_NUM = 8,
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int OUT_WIDTH   = 32,
    parameter int SHIFT       = 0,
    parameter int SATURATE    = 1,
    parameter int LATENCY     = 2
) (
    input  logic                     clkIn,
    input  logic                     resetIn,
    fir_packet_sequencer_if.slave    bus
);
    localparam int PKT_IN  = SAMPLES_NUM * IN_WIDTH;
    localparam int PKT_OUT = SAMPLES_NUM * OUT_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_done;
    logic [PKT_IN-1:0]    w_reorder;
    logic [PKT_OUT-1:0]   w_scaled;

    logic                 r_start;
    logic [PKT_IN-1:0]    r_coreData;
    logic [PKT_OUT-1:0]   r_result;
    logic [PKT_OUT-1:0]   r_tx;
    logic                 r_overrun;
    logic [15:0]          r_frame;
    logic [7:0]           r_drop;

    function automatic logic [OUT_WIDTH-1:0] scale_lane(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] r;
        r = v >>> SHIFT;
        if (SATURATE != 0 && r > SAT_MAX) return SAT_MAX[OUT_WIDTH-1:0];
        if (SATURATE != 0 && r < SAT_MIN) return SAT_MIN[OUT_WIDTH-1:0];
        return r[OUT_WIDTH-1:0];
    endfunction

    // Sample k arrives at the top of the packet and leaves at the bottom, so lanes swap end for end.
    always_comb begin
        w_reorder = '0;
        w_scaled  = '0;
        for (int unsigned k = 0; k < SAMPLES_NUM; k++) begin
            w_reorder[k*IN_WIDTH +: IN_WIDTH] = bus.rxDataIn[(SAMPLES_NUM-1-k)*IN_WIDTH +: IN_WIDTH];
            w_scaled[(SAMPLES_NUM-1-k)*OUT_WIDTH +: OUT_WIDTH] =
                scale_lane(bus.coreResultIn[k*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    // A done and a packet in the same WAIT cycle retire the old job and start the new one.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rxValidIn) begin
                    w_accept = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.coreDoneIn) begin
                    w_done = 1'b1;
                    w_next = S_IDLE;
                    if (bus.rxValidIn) begin
                        w_accept = 1'b1;
                        w_next   = S_WAIT;
                    end
                end else if (bus.rxValidIn) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            r_state    <= S_IDLE;
            r_start    <= 1'b0;
            r_coreData <= '0;
            r_result   <= '0;
            r_tx       <= '0;
            r_overrun  <= 1'b0;
            r_frame    <= '0;
            r_drop     <= '0;
        end else begin
            r_state <= w_next;
            r_start <= w_accept;
            if (w_accept) begin
                r_coreData <= w_reorder;
                r_frame    <= r_frame + 16'd1;
            end
            if (w_done) r_result <= w_scaled;
            if (LATENCY == 2) begin
                if (w_accept) r_tx <= r_result;
            end else begin
                if (w_done) r_tx <= w_scaled;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
                if (r_drop != '1) r_drop <= r_drop + 8'd1;
            end else if (bus.overrunClearIn) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.coreStartOut  = r_start;
    assign bus.coreDataOut   = r_coreData;
    assign bus.txDataOut     = r_tx;
    assign bus.busyOut       = (r_state == S_WAIT);
    assign bus.overrunOut    = r_overrun;
    assign bus.frameCountOut = r_frame;
    assign bus.dropCountOut  = r_drop;
endmodule

// File: tb/tb_fir_packet_sequencer.sv
// Bench for fir_packet_sequencer with two configurations sharing one stimulus stream.
// dut_a uses saturation and two-packet latency. dut_b uses truncation and one-packet latency.
module tb_fir_packet_sequencer;
    localparam int S  = 4;
    localparam int IW = 16;
    localparam int AW = 40;
    localparam int OW = 32;
    localparam int SH = 4;

    logic              clk;
    logic              rst;
    logic              rx;
    logic [S*IW-1:0]   rx_data;
    logic              done;
    logic [S*AW-1:0]   res;
    logic              clr;
    logic              cmp_en;

    int checks;
    int errors;

    fir_packet_sequencer_if #(.SAMPLES_NUM(S), .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) ifa ();
    fir_packet_sequencer_if #(.SAMPLES_NUM(S), .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) ifb ();

    assign ifa.rxValidIn      = rx;
    assign ifa.rxDataIn       = rx_data;
    assign ifa.coreDoneIn     = done;
    assign ifa.coreResultIn   = res;
    assign ifa.overrunClearIn = clr;
    assign ifb.rxValidIn      = rx;
    assign ifb.rxDataIn       = rx_data;
    assign ifb.coreDoneIn     = done;
    assign ifb.coreResultIn   = res;
    assign ifb.overrunClearIn = clr;

    fir_packet_sequencer #(
        .SAMPLES_NUM(S), .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
        .SHIFT(SH), .SATURATE(1), .LATENCY(2)
    ) dut_a (
        .clkIn(clk), .resetIn(rst), .bus(ifa.slave)
    );

    fir_packet_sequencer #(
        .SAMPLES_NUM(S), .IN_WIDTH(IW), .ACC_WIDTH(AW), .OUT_WIDTH(OW),
        .SHIFT(SH), .SATURATE(0), .LATENCY(1)
    ) dut_b (
        .clkIn(clk), .resetIn(rst), .bus(ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
            if (errors >= 100) begin
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    endtask

    // Reference behaviour: a packet is taken when the core is free or is finishing right now.
    function automatic logic [S*IW-1:0] reorder(input logic [S*IW-1:0] pkt);
        logic [S*IW-1:0] o;
        o = '0;
        for (int k = 0; k < S; k++) o[k*IW +: IW] = pkt[(S-k)*IW-1 -: IW];
        return o;
    endfunction

    function automatic logic [S*OW-1:0] scale_pkt(input logic [S*AW-1:0] r, input bit sat);
        logic [S*OW-1:0] o;
        longint v, q, d;
        o = '0;
        d = longint'(1) << SH;
        for (int k = 0; k < S; k++) begin
            v = longint'($signed(r[k*AW +: AW]));
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
            if (sat) begin
                if (q > 64'sh7FFF_FFFF) q = 64'sh7FFF_FFFF;
                if (q < -64'sh8000_0000) q = -64'sh8000_0000;
            end
            o[(S-1-k)*OW +: OW] = q[OW-1:0];
        end
        return o;
    endfunction

    logic            m_busy, m_start, m_ovr;
    logic [S*IW-1:0] m_core;
    logic [15:0]     m_frame;
    logic [7:0]      m_drop;
    logic [S*OW-1:0] m_res, m_txa, m_txb;
    bit              dn, acc, drp;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_start <= 1'b0; m_ovr <= 1'b0;
            m_core <= '0; m_frame <= '0; m_drop <= '0;
            m_res <= '0; m_txa <= '0; m_txb <= '0;
        end else begin
            dn  = m_busy && done;
            acc = rx && (!m_busy || dn);
            drp = rx && !acc;
            m_start <= acc;
            if (acc) begin
                m_core  <= reorder(rx_data);
                m_frame <= m_frame + 16'd1;
                m_txa   <= m_res;
            end
            if (dn) begin
                m_res <= scale_pkt(res, 1'b1);
                m_txb <= scale_pkt(res, 1'b0);
            end
            m_busy <= acc ? 1'b1 : (dn ? 1'b0 : m_busy);
            if (drp) begin
                m_ovr  <= 1'b1;
                m_drop <= (m_drop == 8'd255) ? 8'd255 : m_drop + 8'd1;
            end else if (clr) begin
                m_ovr <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("a_start", ifa.coreStartOut, m_start);
            chk("a_core",  ifa.coreDataOut, m_core);
            chk("a_busy",  ifa.busyOut, m_busy);
            chk("a_ovr",   ifa.overrunOut, m_ovr);
            chk("a_frame", ifa.frameCountOut, m_frame);
            chk("a_drop",  ifa.dropCountOut, m_drop);
            chk("a_tx",    ifa.txDataOut, m_txa);
            chk("b_start", ifb.coreStartOut, m_start);
            chk("b_core",  ifb.coreDataOut, m_core);
            chk("b_busy",  ifb.busyOut, m_busy);
            chk("b_ovr",   ifb.overrunOut, m_ovr);
            chk("b_frame", ifb.frameCountOut, m_frame);
            chk("b_drop",  ifb.dropCountOut, m_drop);
            chk("b_tx",    ifb.txDataOut, m_txb);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_lane();
        case ($urandom_range(0, 4))
            0: return 40'h7F_FFFF_FFFF - 40'($urandom_range(0, 3));
            1: return 40'h80_0000_0000 + 40'($urandom_range(0, 3));
            2: return 40'($signed(16'($urandom())));
            default: return {8'($urandom()), 32'($urandom())};
        endcase
    endfunction

    task automatic rand_res();
        for (int k = 0; k < S; k++) res[k*AW +: AW] = rand_lane();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; rx = 1'b0; done = 1'b0; clr = 1'b0; cmp_en = 1'b0;
        rx_data = '0; res = '0;
        repeat (3) tick();
        cmp_en = 1'b1;
        chk("rst_frame", ifa.frameCountOut, 16'd0);
        chk("rst_drop",  ifa.dropCountOut, 8'd0);
        chk("rst_busy",  ifa.busyOut, 1'b0);
        chk("rst_core",  ifa.coreDataOut, 64'd0);
        chk("rst_tx",    ifb.txDataOut, 128'd0);
        rst = 1'b0;

        rx = 1'b1; rx_data = 64'h1111_2222_3333_4444;
        tick(); rx = 1'b0;
        chk("reorder_core",  ifa.coreDataOut, 64'h4444_3333_2222_1111);
        chk("reorder_start", ifa.coreStartOut, 1'b1);
        chk("reorder_busy",  ifa.busyOut, 1'b1);
        tick();
        chk("start_1cyc", ifa.coreStartOut, 1'b0);

        done = 1'b1;
        res = {40'hFF_FFFF_FFF0, 40'h80_0000_0000, 40'h7F_FFFF_FFFF, 40'h00_0000_1230};
        tick(); done = 1'b0;
        chk("done_busy", ifa.busyOut, 1'b0);
        chk("trunc_tx",  ifb.txDataOut, 128'h00000123_FFFFFFFF_00000000_FFFFFFFF);
        chk("lat2_hold", ifa.txDataOut, 128'd0);
        tick();
        rx = 1'b1; rx_data = 64'hDEAD_BEEF_0123_4567;
        tick(); rx = 1'b0;
        chk("sat_tx", ifa.txDataOut, 128'h00000123_7FFFFFFF_80000000_FFFFFFFF);

        done = 1'b1; res = {4{40'h00_0000_0100}};
        tick(); done = 1'b0;
        chk("lat1_tx", ifb.txDataOut, {4{32'h0000_0010}});
        chk("lat2_old", ifa.txDataOut, 128'h00000123_7FFFFFFF_80000000_FFFFFFFF);
        tick();
        rx = 1'b1; rx_data = 64'h0;
        tick(); rx = 1'b0;
        chk("lat2_tx", ifa.txDataOut, {4{32'h0000_0010}});

        rx = 1'b1;
        tick(); rx = 1'b0;
        chk("ovr_set",   ifa.overrunOut, 1'b1);
        chk("ovr_drop",  ifa.dropCountOut, 8'd1);
        chk("ovr_frame", ifa.frameCountOut, 16'd3);
        chk("ovr_nostart", ifa.coreStartOut, 1'b0);

        rx = 1'b1; done = 1'b1; res = {4{40'h00_0000_0300}};
        tick(); rx = 1'b0; done = 1'b0;
        chk("same_start", ifa.coreStartOut, 1'b1);
        chk("same_busy",  ifa.busyOut, 1'b1);
        chk("same_drop",  ifa.dropCountOut, 8'd1);
        chk("same_frame", ifa.frameCountOut, 16'd4);
        chk("same_txa",   ifa.txDataOut, {4{32'h0000_0010}});
        chk("same_txb",   ifb.txDataOut, {4{32'h0000_0030}});

        rx = 1'b1; clr = 1'b1;
        tick(); rx = 1'b0; clr = 1'b0;
        chk("clr_vs_drop", ifa.overrunOut, 1'b1);
        chk("clr_drop2",   ifa.dropCountOut, 8'd2);
        clr = 1'b1;
        tick(); clr = 1'b0;
        chk("clr_alone", ifa.overrunOut, 1'b0);

        rx = 1'b1;
        repeat (300) tick();
        rx = 1'b0;
        chk("drop_sat", ifa.dropCountOut, 8'd255);
        chk("drop_sat_b", ifb.dropCountOut, 8'd255);

        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("midwait_busy", ifa.busyOut, 1'b0);
        done = 1'b1; rand_res();
        tick(); done = 1'b0;
        chk("late_done_busy", ifb.busyOut, 1'b0);
        chk("late_done_tx",   ifb.txDataOut, 128'd0);

        rx = 1'b1; done = 1'b1;
        repeat (65536) begin
            rx_data = {$urandom(), $urandom()};
            tick();
        end
        rx = 1'b0; done = 1'b0;
        chk("frame_wrap", ifa.frameCountOut, 16'd0);
        chk("wrap_drop",  ifa.dropCountOut, 8'd0);

        repeat (4000) begin
            rst  = ($urandom_range(0, 199) == 0);
            rx   = ($urandom_range(0, 9) < 3);
            done = ($urandom_range(0, 9) < 4);
            clr  = ($urandom_range(0, 19) == 0);
            rx_data = {$urandom(), $urandom()};
            rand_res();
            tick();
        end
        rst = 1'b0; rx = 1'b0; done = 1'b0; clr = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_packet_sequencer.md
# fir_packet_sequencer

Parametrised packet sequencer between the data SPI slave and the FIR core in the FIR filter top level. It unpacks a received SPI packet into core sample order, launches the core, and scales the wide accumulator results to the output width with optional saturation. It double-buffers results for SPI transmit with selectable packet latency, and it detects and counts packets that arrive while the core is busy. This block replaces the fixed 16-in/32-out, two-packet-latency glue logic in the top level.

## Interface
- SAMPLES_NUM, 8, samples per packet, 1..16
- IN_WIDTH, 16, signed input sample width
- ACC_WIDTH, 40, signed core result width per sample
- OUT_WIDTH, 32, signed transmitted sample width, ≤ ACC_WIDTH
- SHIFT, 0, arithmetic right shift applied to results, 0..ACC_WIDTH-1
- SATURATE, 1, 1 = saturate to OUT_WIDTH, 0 = keep low OUT_WIDTH bits
- LATENCY, 2, packets between a sample packet and its transmitted result, 1 or 2

Ports:
- clkIn  in  1  system clock (PLL output)
- resetIn  in  1  synchronous, active-high reset
- rxValidIn  in  1  one-cycle pulse: SPI packet received
- rxDataIn  in  SAMPLES_NUM*IN_WIDTH  packet head; transmitted sample k at [(SAMPLES_NUM-k)*IN_WIDTH-1 -: IN_WIDTH]
- coreStartOut  out  1  one-cycle core start pulse
- coreDataOut  out  SAMPLES_NUM*IN_WIDTH  core samples; sample k at [k*IN_WIDTH +: IN_WIDTH]
- coreDoneIn  in  1  one-cycle pulse: core results valid
- coreResultIn  in  SAMPLES_NUM*ACC_WIDTH  result k at [k*ACC_WIDTH +: ACC_WIDTH]
- txDataOut  out  SAMPLES_NUM*OUT_WIDTH  SPI transmit word; result k at [(SAMPLES_NUM-k)*OUT_WIDTH-1 -: OUT_WIDTH]
- busyOut  out  1  high in WAIT
- overrunOut  out  1  sticky: a packet was dropped
- overrunClearIn  in  1  clears overrunOut
- frameCountOut  out  16  accepted packets, wraps at 65535→0
- dropCountOut  out  8  dropped packets, saturates at 255

## Operation
- The FSM has two states, IDLE and WAIT. Reset puts it in IDLE and sets every output and internal register to 0.
- IDLE + rxValidIn: the block reorders rxDataIn into coreDataOut, pulses coreStartOut, increments frameCountOut and moves to WAIT.
- WAIT + coreDoneIn: each lane is scaled as r = result >>> SHIFT.
  - SATURATE=1: lanes above 2^(OUT_WIDTH-1)-1 clamp to that value; lanes below -2^(OUT_WIDTH-1) clamp to that value.
  - SATURATE=0: the lane keeps r[OUT_WIDTH-1:0].
  - The scaled lanes are stored in resultReg in transmit order, and the FSM moves to IDLE.
- WAIT + rxValidIn without coreDoneIn: the packet is dropped, overrunOut is set, dropCountOut increments, no start is issued and txDataOut is unchanged.
- WAIT + rxValidIn and coreDoneIn in the same cycle: the done is processed first, then the packet is accepted in the same cycle. A new start is issued, the FSM stays in WAIT and no overrun is flagged.
- LATENCY=2: on every accepted rxValidIn, txDataOut loads the resultReg value from before the cycle. The SPI slave shifts this value out during the next packet.
- LATENCY=1: txDataOut loads the scaled results directly on coreDoneIn, and resultReg is unused for output.
- coreDataOut holds its value until the next accepted packet.
- coreDoneIn in IDLE is ignored.
- overrunClearIn in the same cycle as a new drop: set wins.

## Timing
- coreStartOut and the new coreDataOut appear on the cycle after rxValidIn.
- Results appear one cycle after coreDoneIn: resultReg for LATENCY=2, txDataOut for LATENCY=1.
- The block raises busyOut on the cycle after the start condition and lowers it on the cycle after coreDoneIn.
- Counters and overrunOut update on the cycle after the causing event.
- resetIn asserted mid-WAIT: the FSM returns to IDLE on the next edge, and a later coreDoneIn is ignored.
- The core's done-to-next-packet time must be at least 2 cycles for LATENCY=1 so that txDataOut is stable before the SPI slave latches it.

## Test plan
- Reset: hold resetIn for 3 cycles -> every output reads 0 and busyOut=0.
- Reorder, SAMPLES_NUM=4: rxDataIn=0x1111_2222_3333_4444 -> coreDataOut=0x4444_3333_2222_1111 and coreStartOut high for exactly 1 cycle, on the cycle after rxValidIn.
- Scaling, ACC=40, OUT=32, SHIFT=4, SATURATE=1:
  - result 0x00_0000_1230 -> 0x0000_0123
  - result 0x7F_FFFF_FFFF -> 0x7FFF_FFFF
  - result 0x80_0000_0000 -> 0x8000_0000
  - with SATURATE=0, result 0x7F_FFFF_FFFF -> 0xFFFF_FFFF
- Latency: packets P0..P3 with done after each, LATENCY=2 -> txDataOut during P2 carries the results of P0. With LATENCY=1, txDataOut during P1 carries the results of P0.
- Overrun: second rxValidIn while in WAIT -> overrunOut=1, dropCountOut=1, frameCountOut unchanged, no start. Same-cycle done and rx -> start issued, no overrun. 300 drops -> dropCountOut=255.
- Wrap and clear: 65536 accepted packets -> frameCountOut=0. overrunClearIn together with a drop -> overrunOut stays 1.
